// File: rtl/pwm_pkg.sv
// Shared types and defaults for the PWM controller.
package pwm_pkg;

  localparam int WIDTH_DEF = 8;

  // IDLE: PWM stopped; RUN: counting; DRAIN: finishing the current period.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/pwm_ctrl_if.sv
// Configuration/command/status bundle between a PWM user and pwm_ctrl.
//
// Handshake: a configuration moves only in a cycle where cfg_valid and
// cfg_ready are both high. cfg_valid may be raised at any time and does not
// depend on cfg_ready; cfg_ready is low exactly while an accepted
// configuration is still waiting to be applied at a period boundary.
interface pwm_ctrl_if
  import pwm_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);

  logic             cfg_valid;
  logic             cfg_ready;
  logic [WIDTH-1:0] cfg_T;
  logic [WIDTH-1:0] cfg_duty;
  logic             start;
  logic             stop;
  logic [WIDTH-1:0] cont;
  logic             inc;
  logic [WIDTH-1:0] T;
  logic [WIDTH-1:0] duty;
  logic             busy;
  logic             err;
  state_t           state;

  modport master (
    output cfg_valid, cfg_T, cfg_duty, start, stop, cont,
    input  cfg_ready, inc, T, duty, busy, err, state
  );

  modport slave (
    input  cfg_valid, cfg_T, cfg_duty, start, stop, cont,
    output cfg_ready, inc, T, duty, busy, err, state
  );

endinterface

// File: rtl/duty_ramp.sv
// Duty slew: one step of at most STEP from current toward target, landing
// exactly on target when the remaining gap is no larger than STEP.
module duty_ramp #(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic [WIDTH-1:0] target,
  input  logic [WIDTH-1:0] current,
  output logic [WIDTH-1:0] next,
  output logic             done
);

  logic [WIDTH-1:0] gap;

  // Distance to target, then a bounded move that never passes the target.
  always_comb begin
    gap  = (target > current) ? (target - current) : (current - target);
    next = target;
    if (int'(gap) > STEP) begin
      next = (target > current) ? (current + WIDTH'(STEP)) : (current - WIDTH'(STEP));
    end
  end

  assign done = (gap == '0);

endmodule

// File: rtl/pwm_ctrl.sv
// PWM controller: accepts period/duty configurations, applies them at PWM
// period boundaries with a slewed duty, and sequences run/stop of the PWM.
module pwm_ctrl
  import pwm_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int STEP  = 1
) (
  input logic       clock,
  input logic       reset,
  pwm_ctrl_if.slave io
);

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] t_q;
  logic [WIDTH-1:0] duty_q;
  logic [WIDTH-1:0] target_q;
  logic [WIDTH-1:0] pend_t;
  logic [WIDTH-1:0] pend_duty;
  logic             pend;
  logic             err;

  logic             running;
  logic             boundary;
  logic             accept;
  logic             reject;
  logic             clamp;
  logic             cfg_clean;
  logic [WIDTH-1:0] cfg_duty_cl;
  logic             start_req;
  logic             start_bad;
  logic [WIDTH-1:0] eff_t;
  logic [WIDTH-1:0] eff_target;
  logic [WIDTH-1:0] eff_cur;
  logic [WIDTH-1:0] ramp_next;
  logic             ramp_done;

  assign running     = (state != IDLE);
  assign boundary    = running && (io.cont == t_q);
  assign accept      = io.cfg_valid && !pend;
  assign reject      = accept && (io.cfg_T == '0);
  assign clamp       = accept && !reject && (io.cfg_duty > io.cfg_T);
  assign cfg_clean   = accept && !reject && !clamp;
  assign cfg_duty_cl = (io.cfg_duty > io.cfg_T) ? io.cfg_T : io.cfg_duty;
  // start together with stop counts as stop only
  assign start_req   = io.start && !io.stop;
  assign start_bad   = (state == IDLE) && start_req && (t_q == '0);

  // A pending config takes effect at the boundary; the current duty is first
  // clamped into the new period so duty never exceeds T.
  assign eff_t      = pend ? pend_t : t_q;
  assign eff_target = pend ? pend_duty : target_q;
  assign eff_cur    = (duty_q > eff_t) ? eff_t : duty_q;

  duty_ramp #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_ramp (
    .target  (eff_target),
    .current (eff_cur),
    .next    (ramp_next),
    .done    (ramp_done)
  );

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Run/stop sequencing; DRAIN ends at the next boundary unless restarted.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start_req && (t_q != '0)) state_nx = RUN;
      RUN:     if (io.stop) state_nx = DRAIN;
      DRAIN: begin
        if (start_req)     state_nx = RUN;
        else if (boundary) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Period, duty, target and pending-config registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      t_q       <= '0;
      duty_q    <= '0;
      target_q  <= '0;
      pend_t    <= '0;
      pend_duty <= '0;
      pend      <= 1'b0;
    end else begin
      if (boundary) begin
        t_q      <= eff_t;
        target_q <= eff_target;
        duty_q   <= ramp_next;
        pend     <= 1'b0;
      end
      // A config left pending when DRAIN ended is applied directly in IDLE.
      if ((state == IDLE) && pend) begin
        t_q      <= pend_t;
        duty_q   <= pend_duty;
        target_q <= pend_duty;
        pend     <= 1'b0;
      end
      // Placed after the boundary update so a config accepted on a boundary
      // stays pending for the following one.
      if (accept && !reject) begin
        if (state == IDLE) begin
          t_q      <= io.cfg_T;
          duty_q   <= cfg_duty_cl;
          target_q <= cfg_duty_cl;
        end else begin
          pend      <= 1'b1;
          pend_t    <= io.cfg_T;
          pend_duty <= cfg_duty_cl;
        end
      end
    end
  end

  // Sticky error: setting events win over a clean transfer in the same cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                            err <= 1'b0;
    else if (reject || clamp || start_bad) err <= 1'b1;
    else if (cfg_clean)                   err <= 1'b0;
  end

  assign io.cfg_ready = !pend;
  assign io.inc       = running;
  assign io.T         = t_q;
  assign io.duty      = duty_q;
  assign io.busy      = running || pend || !ramp_done;
  assign io.err       = err;
  assign io.state     = state;

endmodule
